// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
//   div_state_t : controller states (IDLE, BUSY, DONE)
//   DIV_DW/SW   : default dividend/quotient and divisor/remainder widths
//   CNT_W       : width of the step counter for the default dividend width
//   DBZ_QUOT    : quotient reported for a zero divisor
package div_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_SW = 4;
  localparam int unsigned CNT_W  = $clog2(DIV_DW + 1);

  localparam logic [DIV_DW-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/seq_div8by4_restoring_if.sv
// Operand/result handshake bundle for the restoring divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, dbz)
//   master : requester side, slave : divider side
interface seq_div8by4_restoring_if
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned SW = DIV_SW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz
  );

endinterface : seq_div8by4_restoring_if

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
//   i_r       : current partial remainder (SW+1 bits)
//   i_q_msb   : dividend bit shifted in this step
//   i_divisor : divisor
//   o_r_next  : partial remainder after the trial subtract/restore
//   o_q_bit   : quotient bit produced by this step
module div_restore_step
  import div_pkg::*;
#(
  parameter int unsigned SW = DIV_SW
) (
  input  logic [SW:0]   i_r,
  input  logic          i_q_msb,
  input  logic [SW-1:0] i_divisor,
  output logic [SW:0]   o_r_next,
  output logic          o_q_bit
);

  // The partial remainder stays below the divisor, so its msb is always 0;
  // carrying it through the trial value keeps the compare exact anyway.
  logic [SW+1:0] w_t;
  logic [SW+1:0] w_d;

  assign w_t = {i_r, i_q_msb};
  assign w_d = (SW+2)'(i_divisor);

  // Trial subtract; keep the shifted value when the divisor does not fit
  always_comb begin
    o_q_bit  = 1'b0;
    o_r_next = (SW+1)'(w_t);
    if (w_t >= w_d) begin
      o_q_bit  = 1'b1;
      o_r_next = (SW+1)'(w_t - w_d);
    end
  end

endmodule : div_restore_step

// File: rtl/seq_div8by4_restoring.sv
// Iterative restoring divider, one quotient bit per clock.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of the operand/result handshake bundle
// A zero divisor skips the iteration and reports all-ones quotient,
// the low dividend bits as remainder, and dbz=1.
module seq_div8by4_restoring
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned SW = DIV_SW
) (
  input  logic                     clk,
  input  logic                     rst,
  seq_div8by4_restoring_if.slave   bus
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_t    r_state;
  div_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q;
  logic [SW:0]   r_r;
  logic [SW-1:0] r_div;
  logic [DW-1:0] r_quot;
  logic [SW-1:0] r_rem;
  logic          r_dbz;

  logic [SW:0]   w_r_next;
  logic          w_q_bit;
  logic          w_accept;
  logic          w_step;
  logic          w_last;

  div_restore_step #(.SW(SW)) u_step (
    .i_r       (r_r),
    .i_q_msb   (r_q[DW-1]),
    .i_divisor (r_div),
    .o_r_next  (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (bus.divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, shift/subtract iteration and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_div  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_q   <= bus.dividend;
      r_r   <= '0;
      r_div <= bus.divisor;
      r_cnt <= CW'(DW);
      if (bus.divisor == '0) begin
        r_quot <= '1;
        r_rem  <= bus.dividend[SW-1:0];
        r_dbz  <= 1'b1;
      end else begin
        r_dbz  <= 1'b0;
      end
    end else if (w_step) begin
      r_q   <= {r_q[DW-2:0], w_q_bit};
      r_r   <= w_r_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quot <= {r_q[DW-2:0], w_q_bit};
        r_rem  <= w_r_next[SW-1:0];
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;

endmodule : seq_div8by4_restoring

// File: tb/tb_seq_div8by4_restoring.sv
// Self-checking bench for seq_div8by4_restoring: directed cases, backpressure,
// mid-operation reset and a full operand sweep against an arithmetic model.
module tb_seq_div8by4_restoring;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  seq_div8by4_restoring_if #(.DW(8), .SW(4)) bus ();

  seq_div8by4_restoring dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor reports all-ones and low dividend bits
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int z);
    if (b == 0) begin
      q = 255; r = a % 16; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endfunction

  // Issue one operation, optionally check latency, hold out_ready low for
  // `hold` cycles while poking in_valid, then complete the result handshake.
  task automatic run_op(input int a, input int b, input int hold, input bit chk_lat);
    int g, cyc, q, r, z;
    ref_div(a, b, q, r, z);
    @(negedge clk);
    g = 0;
    while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
    if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 1);
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk); cyc++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check_eq("out_valid_timeout", 32'(bus.out_valid), 1);
    if (chk_lat) check_eq("latency", 32'(cyc), (b == 0) ? 1 : 9);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(negedge clk);
      check_eq("hold_quot", 32'(bus.quotient), q);
      check_eq("hold_rem", 32'(bus.remainder), r);
      check_eq("hold_in_ready", 32'(bus.in_ready), 0);
      check_eq("hold_out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    check_eq("quotient", 32'(bus.quotient), q);
    check_eq("remainder", 32'(bus.remainder), r);
    check_eq("dbz", 32'(bus.dbz), z);
    if (z == 0) check_eq("invariant", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), a);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_in_ready", 32'(bus.in_ready), 1);
    check_eq("post_out_valid", 32'(bus.out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_quot", 32'(bus.quotient), 0);
    check_eq("rst_rem", 32'(bus.remainder), 0);
    check_eq("rst_dbz", 32'(bus.dbz), 0);

    // Directed cases
    run_op(143, 11, 0, 1'b1);
    run_op(100, 7, 0, 1'b1);
    run_op(255, 1, 0, 1'b1);
    run_op(225, 15, 0, 1'b1);
    run_op(200, 0, 0, 1'b1);
    run_op(9, 3, 0, 1'b1);
    run_op(0, 5, 0, 1'b1);

    // Backpressure: hold the result for 20 cycles with input noise
    run_op(77, 9, 20, 1'b1);

    // Reset during BUSY drops the operation
    @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor  = 4'd6;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("busy_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", 32'(bus.in_ready), 1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 0);
    check_eq("abort_quot", 32'(bus.quotient), 0);
    check_eq("abort_rem", 32'(bus.remainder), 0);
    check_eq("abort_dbz", 32'(bus.dbz), 0);
    repeat (12) begin
      @(negedge clk);
      check_eq("abort_no_valid", 32'(bus.out_valid), 0);
    end
    run_op(50, 6, 0, 1'b1);

    // Full sweep with random result backpressure
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b, int'($urandom_range(0, 2)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_div8by4_restoring
